camera_stream_packer: RTL and testbench

Parametrised N-channel pixel-to-AXI-Stream frame packer between the per-camera link receivers and the S2MM DMA slave port. It selects one of `NUM_CH` pixel streams per capture and packs `PIX_W`-bit pixels into `DATA_W`-bit beats. It bounds each frame by the programmed width × height and marks the final beat with `tlast` and a partial `tkeep`. An optional built-in test-pattern source replaces the camera input.

---
 rtl/camera_stream_packer.sv | 262 ++++++++++++++++++++++++++
 tb/tb_camera_stream_packer.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/camera_stream_packer.sv
// camera_stream_packer
// Selects one of NUM_CH camera pixel streams per capture and packs PIX_W-bit
// pixels into DATA_W-bit AXI-Stream beats. Frames are bounded by the latched
// width x height. The final beat carries tlast and a partial tkeep.
//
// Optional feature: define CAMERA_PACKER_TEST_PATTERN_EN to build an internal
// (x + y) test-pattern source. It is selected by test_mode, which is latched
// on new_capture. Without the macro, test_mode is ignored.
//
// Ports:
//   sys_clk, sys_rst          clock, synchronous active-high reset
//   new_capture               start-of-frame pulse (config sampled here)
//   channel_sel, test_mode    source selection
//   image_width, image_height frame geometry
//   pix_data/valid/ready      per-channel pixel streams (ready combinational)
//   m_axis_*                  packed AXI-Stream output (registered)
//   busy, frame_done,         status: not idle, tlast accepted,
//   capture_ignored           and new_capture dropped while busy
module camera_stream_packer #(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned PIX_W  = 16,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned CNT_W  = 16,
  localparam int unsigned SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst,
  input  logic                     new_capture,
  input  logic [SEL_W-1:0]         channel_sel,
  input  logic                     test_mode,
  input  logic [CNT_W-1:0]         image_width,
  input  logic [CNT_W-1:0]         image_height,
  input  logic [NUM_CH*PIX_W-1:0]  pix_data,
  input  logic [NUM_CH-1:0]        pix_valid,
  output logic [NUM_CH-1:0]        pix_ready,
  output logic [DATA_W-1:0]        m_axis_tdata,
  output logic [DATA_W/8-1:0]      m_axis_tkeep,
  output logic                     m_axis_tlast,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic                     busy,
  output logic                     frame_done,
  output logic                     capture_ignored
);

  localparam int unsigned PPB    = DATA_W / PIX_W;
  localparam int unsigned BPP    = PIX_W / 8;
  localparam int unsigned KEEP_W = DATA_W / 8;
  localparam int unsigned LANE_W = (PPB > 1) ? $clog2(PPB) : 1;
  localparam int unsigned TOT_W  = 2 * CNT_W;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_STREAM,
    ST_DRAIN,
    ST_DONE
  } state_t;

  state_t state, state_n;

  logic [SEL_W-1:0]  cfg_sel;
  logic [CNT_W-1:0]  cfg_w;
  logic [CNT_W-1:0]  cfg_h;
  logic [TOT_W-1:0]  total;
  logic [TOT_W-1:0]  total_c;
  logic [TOT_W-1:0]  pix_cnt;
  logic [CNT_W-1:0]  x;
  logic [CNT_W-1:0]  y;

  logic [LANE_W-1:0] lane, lane_n;
  logic [DATA_W-1:0] pbuf_data, pbuf_data_n;
  logic [KEEP_W-1:0] pbuf_keep, pbuf_keep_n;
  logic              pbuf_last, pbuf_last_n;
  logic              pbuf_full, pbuf_full_n;

  logic              move;
  logic              pack_pending;
  logic              accept;
  logic              last_pix;
  logic [PIX_W-1:0]  chan_pix;
  logic              chan_valid;
  logic [PIX_W-1:0]  src_pix;
  logic              src_valid;
  logic              test_src;

  assign total_c  = TOT_W'(cfg_w) * TOT_W'(cfg_h);
  assign last_pix = (pix_cnt == TOT_W'(total - TOT_W'(1)));

  // A full pack buffer drains when the output register is free this cycle.
  assign move         = pbuf_full && (!m_axis_tvalid || m_axis_tready);
  assign pack_pending = pbuf_full && !move;
  assign accept       = !sys_rst && (state == ST_STREAM) && !pack_pending && src_valid;

  // Selected camera channel.
  always_comb begin
    chan_pix   = '0;
    chan_valid = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (cfg_sel == SEL_W'(k)) begin
        chan_pix   = pix_data[k*PIX_W +: PIX_W];
        chan_valid = pix_valid[k];
      end
    end
  end

  // Only the latched channel is ever offered ready; never while the pattern runs.
  always_comb begin
    pix_ready = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      pix_ready[k] = !sys_rst && (cfg_sel == SEL_W'(k)) && (state == ST_STREAM)
                     && !pack_pending && !test_src;
    end
  end

`ifdef CAMERA_PACKER_TEST_PATTERN_EN
  logic           cfg_test;
  logic [CNT_W:0] xy_sum;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      cfg_test <= 1'b0;
    end else if (state == ST_IDLE && new_capture) begin
      cfg_test <= test_mode;
    end
  end

  // Pattern pixel is (x + y) truncated to the pixel width.
  assign xy_sum    = {1'b0, x} + {1'b0, y};
  assign test_src  = cfg_test;
  assign src_pix   = cfg_test ? PIX_W'(xy_sum) : chan_pix;
  assign src_valid = cfg_test | chan_valid;
`else
  logic unused_tp;

  assign unused_tp = ^{test_mode, y};
  assign test_src  = 1'b0;
  assign src_pix   = chan_pix;
  assign src_valid = chan_valid;
`endif

  // State register.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) state <= ST_IDLE;
    else         state <= state_n;
  end

  // Next-state logic.
  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:   if (new_capture) state_n = ST_LOAD;
      ST_LOAD:   state_n = (total_c == '0) ? ST_DONE : ST_STREAM;
      ST_STREAM: if (accept && last_pix) state_n = ST_DRAIN;
      ST_DRAIN:  if (m_axis_tvalid && m_axis_tready && m_axis_tlast) state_n = ST_DONE;
      ST_DONE:   state_n = ST_IDLE;
      default:   state_n = ST_IDLE;
    endcase
  end

  // Pack buffer next value: empty it on move, then drop an accepted pixel into its lane.
  always_comb begin
    pbuf_data_n = pbuf_data;
    pbuf_keep_n = pbuf_keep;
    pbuf_last_n = pbuf_last;
    pbuf_full_n = pbuf_full;
    lane_n      = lane;
    if (move) begin
      pbuf_data_n = '0;
      pbuf_keep_n = '0;
      pbuf_last_n = 1'b0;
      pbuf_full_n = 1'b0;
    end
    if (accept) begin
      for (int i = 0; i < PPB; i++) begin
        if (lane == LANE_W'(i)) begin
          pbuf_data_n[i*PIX_W +: PIX_W] = src_pix;
          pbuf_keep_n[i*BPP +: BPP]     = '1;
        end
      end
      if (lane == LANE_W'(PPB - 1) || last_pix) begin
        pbuf_full_n = 1'b1;
        pbuf_last_n = last_pix;
        lane_n      = '0;
      end else begin
        lane_n = LANE_W'(lane + LANE_W'(1));
      end
    end
  end

  // Config, counters, pack buffer, output register and status pulses.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      cfg_sel         <= '0;
      cfg_w           <= '0;
      cfg_h           <= '0;
      total           <= '0;
      pix_cnt         <= '0;
      x               <= '0;
      y               <= '0;
      lane            <= '0;
      pbuf_data       <= '0;
      pbuf_keep       <= '0;
      pbuf_last       <= 1'b0;
      pbuf_full       <= 1'b0;
      m_axis_tdata    <= '0;
      m_axis_tkeep    <= '0;
      m_axis_tlast    <= 1'b0;
      m_axis_tvalid   <= 1'b0;
      busy            <= 1'b0;
      frame_done      <= 1'b0;
      capture_ignored <= 1'b0;
    end else begin
      if (state == ST_IDLE && new_capture) begin
        cfg_sel <= channel_sel;
        cfg_w   <= image_width;
        cfg_h   <= image_height;
      end

      if (state == ST_LOAD) begin
        total     <= total_c;
        pix_cnt   <= '0;
        x         <= '0;
        y         <= '0;
        lane      <= '0;
        pbuf_data <= '0;
        pbuf_keep <= '0;
        pbuf_last <= 1'b0;
        pbuf_full <= 1'b0;
      end else begin
        if (accept) begin
          pix_cnt <= TOT_W'(pix_cnt + TOT_W'(1));
          // Column wraps at the line end; packing continues across lines.
          if (x == CNT_W'(cfg_w - CNT_W'(1))) begin
            x <= '0;
            y <= CNT_W'(y + CNT_W'(1));
          end else begin
            x <= CNT_W'(x + CNT_W'(1));
          end
        end
        lane      <= lane_n;
        pbuf_data <= pbuf_data_n;
        pbuf_keep <= pbuf_keep_n;
        pbuf_last <= pbuf_last_n;
        pbuf_full <= pbuf_full_n;
      end

      if (m_axis_tvalid && m_axis_tready) m_axis_tvalid <= 1'b0;
      if (move) begin
        m_axis_tdata  <= pbuf_data;
        m_axis_tkeep  <= pbuf_keep;
        m_axis_tlast  <= pbuf_last;
        m_axis_tvalid <= 1'b1;
      end

      busy            <= (state_n != ST_IDLE);
      frame_done      <= (state == ST_DONE);
      capture_ignored <= new_capture && (state != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_camera_stream_packer.sv
// Bench for camera_stream_packer: frames built from random pixels (or the
// test pattern), expected beats derived by chunking the pixel list and
// checked by an independent output monitor.
module tb_camera_stream_packer;

  localparam int NUM_CH = 2;
  localparam int PIX_W  = 16;
  localparam int DATA_W = 64;
  localparam int CNT_W  = 16;
  localparam int PPB    = DATA_W / PIX_W;
`ifdef CAMERA_PACKER_TEST_PATTERN_EN
  localparam bit TP_EN = 1'b1;
`else
  localparam bit TP_EN = 1'b0;
`endif

  logic                    sys_clk;
  logic                    sys_rst;
  logic                    new_capture;
  logic [0:0]              channel_sel;
  logic                    test_mode;
  logic [CNT_W-1:0]        image_width;
  logic [CNT_W-1:0]        image_height;
  logic [NUM_CH*PIX_W-1:0] pix_data;
  logic [NUM_CH-1:0]       pix_valid;
  logic [NUM_CH-1:0]       pix_ready;
  logic [DATA_W-1:0]       m_axis_tdata;
  logic [DATA_W/8-1:0]     m_axis_tkeep;
  logic                    m_axis_tlast;
  logic                    m_axis_tvalid;
  logic                    m_axis_tready;
  logic                    busy;
  logic                    frame_done;
  logic                    capture_ignored;

  camera_stream_packer #(
    .NUM_CH(NUM_CH), .PIX_W(PIX_W), .DATA_W(DATA_W), .CNT_W(CNT_W)
  ) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .new_capture(new_capture),
    .channel_sel(channel_sel), .test_mode(test_mode),
    .image_width(image_width), .image_height(image_height),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
    .m_axis_tlast(m_axis_tlast), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .busy(busy), .frame_done(frame_done),
    .capture_ignored(capture_ignored)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [PIX_W-1:0]  pix_q[$];
  logic [DATA_W-1:0] exp_d[$];
  logic [7:0]        exp_k[$];
  logic              exp_l[$];

  int sel        = 0;
  int vpct       = 100;
  int rmode      = 0;
  bit tm_use     = 1'b0;
  int acc_cnt    = 0;
  int fd_cnt     = 0;
  int ci_cnt     = 0;
  int beat_cnt   = 0;
  int ready_viol = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Pixel source: presents the next queued pixel on the selected channel.
  initial begin
    bit acc;
    pix_valid = '0;
    pix_data  = '0;
    forever begin
      @(negedge sys_clk);
      acc = pix_valid[sel] && pix_ready[sel];
      if (acc) acc_cnt++;
      @(posedge sys_clk);
      #1;
      if (acc && pix_q.size() > 0) void'(pix_q.pop_front());
      for (int k = 0; k < NUM_CH; k++) begin
        pix_valid[k] = 1'($urandom_range(1));
        pix_data[k*PIX_W +: PIX_W] = PIX_W'($urandom);
      end
      pix_valid[sel] = (pix_q.size() > 0) && ($urandom_range(99) < vpct);
      if (pix_q.size() > 0) pix_data[sel*PIX_W +: PIX_W] = pix_q[0];
    end
  end

  // Downstream ready: always, fixed 1-0-0-1 pattern, random, or never.
  initial begin
    logic [3:0] pat;
    int cyc;
    pat = 4'b1001;
    cyc = 0;
    m_axis_tready = 1'b1;
    forever begin
      @(posedge sys_clk);
      #1;
      cyc++;
      case (rmode)
        0:       m_axis_tready = 1'b1;
        1:       m_axis_tready = pat[cyc % 4];
        2:       m_axis_tready = 1'($urandom_range(1));
        default: m_axis_tready = 1'b0;
      endcase
    end
  end

  // Output monitor: scoreboard pop on handshake, hold stability while stalled.
  initial begin
    bit               held;
    logic [DATA_W-1:0] hd;
    logic [7:0]        hk;
    logic              hl;
    logic [NUM_CH-1:0] allowed;
    held = 1'b0;
    forever begin
      @(negedge sys_clk);
      if (sys_rst) begin
        held = 1'b0;
      end else begin
        if (frame_done) fd_cnt++;
        if (capture_ignored) ci_cnt++;
        allowed = tm_use ? '0 : NUM_CH'(1) << sel;
        if ((pix_ready & ~allowed) != '0) ready_viol++;
        if (held) begin
          check("hold_stable",
                64'({m_axis_tvalid, m_axis_tdata == hd, m_axis_tkeep == hk, m_axis_tlast == hl}),
                64'(4'b1111));
        end
        if (m_axis_tvalid && m_axis_tready) begin
          held = 1'b0;
          beat_cnt++;
          if (exp_d.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_beat: got data 0x%0h with no beat expected", m_axis_tdata);
          end else begin
            check("beat_data", 64'(m_axis_tdata), 64'(exp_d.pop_front()));
            check("beat_keep_last", 64'({m_axis_tkeep, m_axis_tlast}),
                  64'({exp_k.pop_front(), exp_l.pop_front()}));
          end
        end else if (m_axis_tvalid) begin
          held = 1'b1;
          hd = m_axis_tdata;
          hk = m_axis_tkeep;
          hl = m_axis_tlast;
        end else begin
          held = 1'b0;
        end
      end
    end
  end

  // One capture: model the pixel list, queue expected beats, run to frame_done.
  task automatic run_frame(input int ch, input int w, input int h, input int vp,
                           input int rm, input bit tm, input int inj);
    logic [PIX_W-1:0]  px[$];
    logic [DATA_W-1:0] d;
    logic [7:0]        k;
    int total, fd0, ci0, v0, lat;
    bit use_tp;
    use_tp = tm && TP_EN;
    total  = w * h;
    for (int p = 0; p < total; p++) begin
      if (use_tp) px.push_back(PIX_W'((p % w) + (p / w)));
      else        px.push_back(PIX_W'($urandom));
    end
    for (int b = 0; b < total; b += PPB) begin
      d = '0;
      k = '0;
      for (int l = 0; l < PPB; l++) begin
        if (b + l < total) begin
          d[l*PIX_W +: PIX_W] = px[b+l];
          k[l*2 +: 2] = 2'b11;
        end
      end
      exp_d.push_back(d);
      exp_k.push_back(k);
      exp_l.push_back(b + PPB >= total);
    end
    @(posedge sys_clk);
    #1;
    vpct = vp;
    rmode = rm;
    tm_use = use_tp;
    sel = ch;
    if (!use_tp) foreach (px[i]) pix_q.push_back(px[i]);
    channel_sel  = 1'(ch);
    image_width  = CNT_W'(w);
    image_height = CNT_W'(h);
    test_mode    = tm;
    new_capture  = 1'b1;
    fd0 = fd_cnt;
    ci0 = ci_cnt;
    v0  = ready_viol;
    lat = -1;
    for (int i = 1; i <= 4000 && lat < 0; i++) begin
      @(posedge sys_clk);
      #1;
      if (i == 1) new_capture = 1'b0;
      if (inj > 0 && i == inj) begin
        new_capture = 1'b1;
        image_width = CNT_W'(3);
        channel_sel = ~channel_sel;
      end
      if (inj > 0 && i == inj + 1) new_capture = 1'b0;
      if (frame_done) lat = i;
    end
    if (lat < 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL frame_timeout: got no frame_done expected one (w=%0d h=%0d)", w, h);
    end
    repeat (3) @(posedge sys_clk);
    #1;
    check("beats_left", 64'(exp_d.size()), 64'(0));
    check("pixels_left", 64'(pix_q.size()), 64'(0));
    check("frame_done_count", 64'(fd_cnt - fd0), 64'(1));
    check("ready_violations", 64'(ready_viol - v0), 64'(0));
    check("capture_ignored_count", 64'(ci_cnt - ci0), 64'(inj > 0 ? 1 : 0));
    if (vp == 100 && rm == 0 && lat >= 0)
      check("frame_latency", 64'(lat), 64'(total == 0 ? 3 : total + 5));
    exp_d.delete();
    exp_k.delete();
    exp_l.delete();
    pix_q.delete();
  endtask

  // Width-8 frame on ch0 interrupted by reset after npix accepted pixels.
  task automatic reset_mid(input int npix, input int rm);
    int a0;
    bit got;
    @(posedge sys_clk);
    #1;
    vpct = 100;
    rmode = rm;
    tm_use = 1'b0;
    sel = 0;
    for (int i = 0; i < 8; i++) pix_q.push_back(PIX_W'($urandom));
    channel_sel  = 1'b0;
    image_width  = CNT_W'(8);
    image_height = CNT_W'(1);
    test_mode    = 1'b0;
    new_capture  = 1'b1;
    a0  = acc_cnt;
    got = 1'b0;
    for (int i = 1; i <= 200 && !got; i++) begin
      @(posedge sys_clk);
      #1;
      if (i == 1) new_capture = 1'b0;
      if (acc_cnt - a0 >= npix) got = 1'b1;
    end
    check("reset_setup_pixels", 64'(acc_cnt - a0), 64'(npix));
    check("busy_before_reset", 64'(busy), 64'(1));
    check("tvalid_before_reset", 64'(m_axis_tvalid), 64'(npix >= 5 ? 1 : 0));
    sys_rst = 1'b1;
    pix_q.delete();
    @(posedge sys_clk);
    #1;
    sys_rst = 1'b0;
    rmode = 0;
    @(negedge sys_clk);
    check("tvalid_after_reset", 64'(m_axis_tvalid), 64'(0));
    check("busy_after_reset", 64'(busy), 64'(0));
    check("tkeep_after_reset", 64'(m_axis_tkeep), 64'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got simulation still running expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    sys_rst      = 1'b1;
    new_capture  = 1'b0;
    channel_sel  = 1'b0;
    test_mode    = 1'b0;
    image_width  = '0;
    image_height = '0;
    repeat (2) @(posedge sys_clk);
    #1;
    check("rst_tvalid", 64'(m_axis_tvalid), 64'(0));
    check("rst_tlast", 64'(m_axis_tlast), 64'(0));
    check("rst_tdata", 64'(m_axis_tdata), 64'(0));
    check("rst_tkeep", 64'(m_axis_tkeep), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_frame_done", 64'(frame_done), 64'(0));
    check("rst_capture_ignored", 64'(capture_ignored), 64'(0));
    check("rst_pix_ready", 64'(pix_ready), 64'(0));
    sys_rst = 1'b0;
    repeat (2) @(posedge sys_clk);

    run_frame(0, 6, 2, 100, 0, 1'b0, 0);
    run_frame(1, 5, 1, 100, 0, 1'b0, 0);
    run_frame(0, 8, 1, 100, 1, 1'b0, 0);
    run_frame(1, 7, 2, 100, 1, 1'b0, 0);
    run_frame(0, 0, 7, 100, 0, 1'b0, 0);
    run_frame(0, 8, 2, 100, 0, 1'b0, 5);
    run_frame(0, 4, 2, 100, 0, 1'b1, 0);
    run_frame(1, 9, 3, 100, 0, 1'b1, 0);
    reset_mid(3, 0);
    run_frame(0, 5, 1, 100, 0, 1'b0, 0);
    reset_mid(6, 3);
    run_frame(1, 7, 1, 100, 0, 1'b0, 0);
    for (int r = 0; r < 8; r++) begin
      run_frame($urandom_range(1), $urandom_range(1, 9), $urandom_range(1, 3),
                $urandom_range(40, 100), 2, 1'b0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
